// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock with bounded retries, and
// holds the downstream system in reset until the PLL is trusted.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               clkin1,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               soft_rst,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               locked_ok,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt
);

    localparam int unsigned CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic               w_lock_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [LOSS_W-1:0]  r_loss;
    logic [LOSS_W-1:0]  w_loss_nxt;
    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               r_locked_ok;
    logic               r_fault;

    sync_2ff u_lock_sync (
        .clk   (clkin1),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;

        if (soft_rst) begin
            w_state_nxt = S_RST;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                S_RST: begin
                    if (r_cnt == RST_LAST)
                        w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // A lock arriving on the timeout cycle still wins.
                    if (w_lock_s) begin
                        w_state_nxt = S_STABLE;
                    end else if (r_cnt == TO_LAST) begin
                        if (r_retry == RETRY_MAX) begin
                            w_state_nxt = S_FAULT;
                        end else begin
                            w_state_nxt = S_RST;
                            w_retry_nxt = r_retry + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s)
                        w_state_nxt = S_WAIT;
                    else if (r_cnt == STABLE_LAST)
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = S_RST;
                        if (r_loss != '1)
                            w_loss_nxt = r_loss + 1'b1;
                    end
                end
                S_FAULT: ;
                default: w_state_nxt = S_RST;
            endcase
        end

        if (w_state_nxt == S_RUN)
            w_retry_nxt = '0;

        // Holding soft_rst pins the counter so the pulse restarts in full on release.
        if (soft_rst || (w_state_nxt != r_state))
            w_cnt_nxt = '0;
        else if ((r_state == S_RUN) || (r_state == S_FAULT))
            w_cnt_nxt = r_cnt;
        else
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked_ok <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            // Outputs decode the next state so they move on the same edge as r_state.
            r_pll_rst   <= (w_state_nxt == S_RST) || (w_state_nxt == S_FAULT);
            r_sys_rst_n <= (w_state_nxt == S_RUN);
            r_locked_ok <= (w_state_nxt == S_RUN);
            r_fault     <= (w_state_nxt == S_FAULT);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst_n     = r_sys_rst_n;
    assign locked_ok     = r_locked_ok;
    assign fault         = r_fault;
    assign retry_cnt     = r_retry;
    assign lock_loss_cnt = r_loss;

endmodule
